// File: rtl/sign_mag_bcd.sv
// sign_mag_bcd: sign-magnitude word to sign flag plus packed BCD via iterative double-dabble.
// Latency N cycles start->done_tick, one per N+1; start is ignored (not queued) while ready=0.
module sign_mag_bcd #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   sm_in,
  output logic           ready,
  output logic           done_tick,
  output logic           sign,
  output logic           neg_zero,
  output logic [4*D-1:0] bcd
);

  localparam int CW = $clog2(N);

  function automatic logic [63:0] pow10(input int d);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < d; i++) r = r * 64'd10;
    return r;
  endfunction

  // The top digit has no carry-out, so D digits must cover the largest magnitude.
  if (N < 2 || pow10(D) <= ((64'd1 << (N - 1)) - 64'd1)) begin : g_bad_params
    $error("sign_mag_bcd: need N >= 2 and 10^D > 2^(N-1)-1");
  end

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-2:0]    mag_shift;
  logic [4*D-1:0]  bcd_work;
  logic [4*D-1:0]  bcd_adj;
  logic [4*D-1:0]  bcd_shift;
  logic [CW-1:0]   cnt;
  logic            pend_sign;
  logic            mag_nz;
  logic            last_step;

  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < D; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_shift = {bcd_adj[4*D-2:0], mag_shift[N-2]};
  assign last_step = (cnt == CW'(1));

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = OP;
      end
      OP: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done_tick = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers load on the final shift edge so they are already valid in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mag_shift <= '0;
      bcd_work  <= '0;
      cnt       <= '0;
      pend_sign <= 1'b0;
      mag_nz    <= 1'b0;
      bcd       <= '0;
      sign      <= 1'b0;
      neg_zero  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_shift <= sm_in[N-2:0];
            pend_sign <= sm_in[N-1];
            mag_nz    <= |sm_in[N-2:0];
            bcd_work  <= '0;
            cnt       <= CW'(N - 1);
          end
        end
        OP: begin
          bcd_work  <= bcd_shift;
          mag_shift <= mag_shift << 1;
          cnt       <= cnt - CW'(1);
          if (last_step) begin
            bcd      <= bcd_shift;
            sign     <= pend_sign & mag_nz;
            neg_zero <= pend_sign & ~mag_nz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sign_mag_bcd.md
# sign_mag_bcd

Sequential decoder that turns a sign-magnitude word, as produced by the team's sign-magnitude arithmetic blocks, into an explicit sign flag plus packed BCD digits for the seven-segment display path. It runs an iterative shift-and-add-3 (double-dabble) conversion under a start/ready/done handshake. Each conversion takes one cycle per magnitude bit. It sits between the arithmetic datapath and the display multiplexer.

## Interface

Parameters:
- N, 8, total word width: 1 sign bit (MSB) plus N-1 magnitude bits
- D, 3, number of BCD output digits; must satisfy 10^D > 2^(N-1)-1 (elaboration-time check)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion of sm_in; honoured only when ready=1
- sm_in  input  N  sign-magnitude operand; sampled on the accepting edge only
- ready  output  1  high exactly when the FSM is in IDLE
- done_tick  output  1  one-cycle pulse: result outputs are updated this cycle
- sign  output  1  result sign (1 = negative); forced 0 for zero magnitude
- neg_zero  output  1  high when the converted input was sign=1, magnitude=0
- bcd  output  4*D  packed digits; bcd[3:0] = units, bcd[4*D-1:4*D-4] = most significant

## Operation

- FSM states: IDLE, OP, DONE.
- IDLE: ready=1. On start=1, latch magnitude sm_in[N-2:0] into the shift register, latch sm_in[N-1] as the pending sign, clear the BCD working register, load the iteration counter with N-1, and go to OP.
- OP: each cycle, for every working digit >=5, add 3 to that digit. Then shift {bcd_work, mag_shift} left by one, so the magnitude MSB enters the units digit LSB. Decrement the counter. After the (N-1)th shift, go to DONE.
- DONE: copy the working register to bcd. Set sign = pending_sign AND (magnitude != 0). Set neg_zero = pending_sign AND (magnitude == 0). Assert done_tick. Go to IDLE next cycle.
- bcd, sign and neg_zero are registered and change only in DONE. They hold the last result until the next DONE.
- start is ignored outside IDLE, with no queuing. sm_in changes during OP/DONE have no effect.
- Working digit adders are 4 bits wide. Overflow out of the top digit cannot occur when the D constraint holds.
- Magnitude 0 takes the full N-1 iterations; there is no early termination.

## Timing

- Reset values: state=IDLE, ready=1, done_tick=0, sign=0, neg_zero=0, bcd=0, counter=0, working registers=0.
- Start accepted at edge k (IDLE, start=1):
  - OP for cycles k+1 … k+N-1
  - DONE in cycle k+N: done_tick=1, outputs valid from this cycle
  - IDLE in cycle k+N+1
- Latency from start to done_tick: N cycles. Throughput: one conversion per N+1 cycles.
- ready is 0 in OP and DONE. The earliest back-to-back start is accepted at edge k+N+1.
- start=1 together with reset=1: reset wins and no conversion begins.
- Reset asserted during OP or DONE: return to IDLE on that edge with all outputs at reset values. No done_tick is produced for the aborted conversion.
- done_tick is never high for more than one consecutive cycle.

## Test plan

- Reset, then start with sm_in=8'h7F (+127) at edge k -> ready=0 for cycles k+1..k+8; done_tick=1 only in cycle k+8 with bcd=12'h127, sign=0, neg_zero=0; ready=1 in cycle k+9.
- sm_in=8'h85 (-5) -> bcd=12'h005, sign=1, neg_zero=0. Then sm_in=8'h0C (+12) -> bcd=12'h012, sign=0.
- sm_in=8'h80 (negative zero) -> bcd=12'h000, sign=0, neg_zero=1. Then sm_in=8'h00 -> bcd=12'h000, sign=0, neg_zero=0.
- Start +100 (8'h64), then pulse start with sm_in=8'hFF at cycle k+3 -> second request ignored, done_tick once at k+8 with bcd=12'h100. Start again at edge k+9 with 8'hFF -> done_tick at k+17 with bcd=12'h127, sign=1.
- Complete -127, then start +64 (8'h40) and assert reset at cycle k+4 -> no done_tick; bcd=0, sign=0, neg_zero=0, ready=1 from cycle k+5.
- Exhaustive sweep of all 256 inputs for N=8, D=3, each started at ready -> bcd matches decimal |value|, sign and neg_zero per rules, and every done_tick falls exactly N cycles after its start.
